prog_mem: RTL
=============

# prog_mem

Parametrised, loadable instruction memory for the pipelined CPU fetch stage. A handshake load port writes the program word by word after reset, replacing hard-coded contents. A registered fetch port returns big-endian 32-bit instructions with stall hold. Misaligned, out-of-range and not-yet-loaded fetches are flagged and return a NOP.

## Interface
Parameters:
- `DEPTH_WORDS`, default 20: number of 32-bit words; byte span is 4*DEPTH_WORDS.
- `NOP_WORD`, default 32'h0000_0020: word returned on fault or when not valid (add $zero,$zero,$zero).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ld_valid` in 1: load word offered.
- `ld_ready` out 1: load word accepted when ld_valid & ld_ready.
- `ld_data` in 32: instruction word; bits [31:24] are the byte at the lowest address.
- `ld_last` in 1: marks the final word of the program.
- `ld_overflow` out 1: sticky; set when a word is offered with the memory full.
- `reload` in 1: one-cycle pulse; returns the block to LOAD.
- `running` out 1: high in RUN.
- `pc` in 32: byte address for fetch.
- `fetch_en` in 1: request a fetch this cycle.
- `stall` in 1: hold fetch outputs.
- `instr` out 32: fetched instruction.
- `instr_valid` out 1: instr is a real fetch result.
- `fault` out 1: the last fetch was misaligned, out of range or unloaded.

## Operation
- States: LOAD, RUN. Reset enters LOAD.
- LOAD:
  - ld_ready = 1.
  - Each accepted word is written at index wr_ptr, then wr_ptr increments.
  - When the accepted word has ld_last = 1, loaded_cnt = wr_ptr+1 and the state moves to RUN.
- Full memory in LOAD (wr_ptr == DEPTH_WORDS):
  - ld_ready = 0.
  - If ld_valid is high, set ld_overflow.
  - Move to RUN with loaded_cnt = DEPTH_WORDS.
- RUN:
  - ld_ready = 0.
  - A fetch is taken when fetch_en & !stall.
  - Word index = pc >> 2.
- Fault conditions: pc[1:0] != 0, or index >= loaded_cnt (which also covers index >= DEPTH_WORDS).
  - On fault: instr = NOP_WORD, fault = 1, instr_valid = 1.
  - Otherwise: instr = mem[index], fault = 0.
- fetch_en = 0 in RUN without stall: instr = NOP_WORD, instr_valid = 0, fault = 0.
- Fetch in LOAD: ignored. Outputs read NOP_WORD, instr_valid = 0, fault = 0.
- reload in RUN:
  - Next state LOAD, wr_ptr = 0, loaded_cnt = 0, ld_overflow cleared.
  - Memory contents are retained but unreachable until reloaded.
- reload in LOAD: restarts wr_ptr at 0.
- reload in the same cycle as an accepted ld_last: reload wins. The word is still written, state stays LOAD, wr_ptr = 0.
- Memory array is not cleared by reset. Only the control registers are reset.

## Timing
- Reset values: state LOAD, wr_ptr 0, loaded_cnt 0, ld_ready 1 (derived from state), ld_overflow 0, running 0, instr NOP_WORD, instr_valid 0, fault 0.
- Load write: takes effect on the accepting edge. Throughput is 1 word/cycle.
- RUN entry: running rises the cycle after ld_last is accepted. The first fetch may be presented that same cycle.
- Fetch latency: 1 cycle. pc sampled at edge N gives instr/instr_valid/fault valid after edge N.
- Stall high: instr, instr_valid and fault hold their values. pc and fetch_en are ignored.
- Stall has no effect in LOAD.
- Reset mid-load or mid-run: abandons the operation next edge. Outputs take reset values.

## Structure
- `prog_mem_pkg`: state enum (LOAD, RUN) and default NOP constant.
- Sub-module `prog_mem_store`: DEPTH_WORDS x 32 array with synchronous write port and synchronous registered read port with read-enable (hold on stall).
- Top level holds the FSM, pointers, fault logic and output mux.

## Test plan
- Reset, load 0x8D090000, 0x8D0A0004, 0x012A5820 (last) -> running = 1 next cycle. Fetch pc = 4 -> instr 0x8D0A0004, instr_valid 1, fault 0, one cycle later.
- pc = 8, then pc = 12 after that load -> 0x012A5820 valid. pc = 12 (>= loaded_cnt 3) -> instr 0x00000020, fault 1.
- pc = 6 -> fault 1, NOP. Stall high for 3 cycles with pc changing -> outputs frozen at the previous value.
- DEPTH_WORDS = 4, offer 5 words without ld_last -> 4 written, ld_ready drops, ld_overflow 1, running 1. pc = 12 returns word 3.
- In RUN pulse reload -> running 0 and ld_ready 1 next cycle. Fetch pc = 0 returns instr_valid 0. Reload of 1 word 0xAD0B0008 (last) -> pc = 0 returns 0xAD0B0008.
- Assert rst_n = 0 mid-load after 2 words -> all outputs at reset values. Reload from wr_ptr 0 succeeds.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared types and constants for the loadable instruction memory
package prog_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // add $zero,$zero,$zero
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0020;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/prog_mem_if.sv
// rtl/prog_mem_if.sv - load handshake and fetch port bundle for prog_mem
interface prog_mem_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_overflow;
    logic        reload;
    logic        running;
    logic [31:0] pc;
    logic        fetch_en;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;

    modport master (
        output ld_valid, ld_data, ld_last, reload, pc, fetch_en, stall,
        input  ld_ready, ld_overflow, running, instr, instr_valid, fault
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, pc, fetch_en, stall,
        output ld_ready, ld_overflow, running, instr, instr_valid, fault
    );
endinterface

// File: rtl/prog_mem_store.sv
// rtl/prog_mem_store.sv - word array with sync write and registered, enable-gated read
module prog_mem_store #(
    parameter int DEPTH_WORDS = 20,
    parameter int AW          = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Contents survive reset; the read register simply holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - loadable instruction memory: LOAD/RUN control, fault check, fetch output
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 20,
    parameter logic [31:0] NOP_WORD    = NOP_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    prog_mem_if.slave bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(DEPTH_WORDS + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH_WORDS);

    state_e        state_q, state_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] loaded_cnt_q, loaded_cnt_d;
    logic          ld_overflow_q, ld_overflow_d;
    logic          instr_valid_q, instr_valid_d;
    logic          fault_q, fault_d;
    logic          sel_mem_q, sel_mem_d;

    logic          wr_en;
    logic          rd_en;
    logic          ld_ready;
    logic [29:0]   fetch_idx;
    logic          fetch_bad;
    logic [31:0]   rd_data;

    assign ld_ready  = (state_q == ST_LOAD) && (wr_ptr_q != FULL);
    assign fetch_idx = bus.pc[31:2];
    // loaded_cnt never exceeds DEPTH_WORDS, so this also rejects indices past the array
    assign fetch_bad = !is_aligned(bus.pc[1:0]) || (fetch_idx >= 30'(loaded_cnt_q));

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        loaded_cnt_d  = loaded_cnt_q;
        ld_overflow_d = ld_overflow_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        sel_mem_d     = sel_mem_q;
        wr_en         = 1'b0;
        rd_en         = 1'b0;

        case (state_q)
            ST_LOAD: begin
                instr_valid_d = 1'b0;
                fault_d       = 1'b0;
                sel_mem_d     = 1'b0;
                if (wr_ptr_q == FULL) begin
                    ld_overflow_d = ld_overflow_q | bus.ld_valid;
                    loaded_cnt_d  = FULL;
                    state_d       = ST_RUN;
                end else if (bus.ld_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + CW'(1);
                    if (bus.ld_last) begin
                        loaded_cnt_d = wr_ptr_q + CW'(1);
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (bus.fetch_en) begin
                        instr_valid_d = 1'b1;
                        fault_d       = fetch_bad;
                        sel_mem_d     = !fetch_bad;
                        rd_en         = !fetch_bad;
                    end else begin
                        instr_valid_d = 1'b0;
                        fault_d       = 1'b0;
                        sel_mem_d     = 1'b0;
                    end
                end
            end
        endcase

        // A same-cycle ld_last still writes its word, but reload decides the state.
        if (bus.reload) begin
            state_d       = ST_LOAD;
            wr_ptr_d      = '0;
            loaded_cnt_d  = '0;
            ld_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            wr_ptr_q      <= '0;
            loaded_cnt_q  <= '0;
            ld_overflow_q <= 1'b0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            sel_mem_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            loaded_cnt_q  <= loaded_cnt_d;
            ld_overflow_q <= ld_overflow_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            sel_mem_q     <= sel_mem_d;
        end
    end

    prog_mem_store #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_store (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(AW'(wr_ptr_q)),
        .wr_data(bus.ld_data),
        .rd_en  (rd_en),
        .rd_addr(AW'(fetch_idx)),
        .rd_data(rd_data)
    );

    assign bus.ld_ready    = ld_ready;
    assign bus.ld_overflow = ld_overflow_q;
    assign bus.running     = (state_q == ST_RUN);
    assign bus.instr       = sel_mem_q ? rd_data : NOP_WORD;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fault       = fault_q;

endmodule
